m_trap_ctrl: RTL and testbench

Machine-mode trap sequencer for the CSR group (mstatus, mtvec, mepc, mcause, mtval, mip, mie). It arbitrates between three event sources: a synchronous exception from commit, an `mret` from commit, and pending enabled interrupts. It then sequences the CSR side-effect writes, flushes the pipeline and hands a redirect PC to fetch over a valid/ready handshake. It sits between the commit stage, the CSR file and the fetch unit.

---
 rtl/m_trap_ctrl.sv | 161 ++++++++++++++++
 tb/tb_m_trap_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exception / mret / interrupt, issues CSR writes,
// a flush pulse and a redirect handshake. Optional feature macro: TRAP_VECTORED_EN.
module m_trap_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid_i,
    input  logic [4:0]      exc_cause_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_valid_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mip_i,
    input  logic [XLEN-1:0] mie_i,
    output logic            busy_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            mstatus_we_o,
    output logic            mepc_we_o,
    output logic            mcause_we_o,
    output logic            mtval_we_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o
);

    localparam int unsigned MIE_B  = 3;
    localparam int unsigned MPIE_B = 7;
    localparam int unsigned MPP_LO = 11;
    localparam int unsigned MSI_B  = 3;
    localparam int unsigned MTI_B  = 7;
    localparam int unsigned MEI_B  = 11;

    typedef enum logic [1:0] {IDLE, TRAP, RET, REDIR} state_t;

    state_t          state, state_next;
    logic            accept_trap, accept_ret;
    logic [XLEN-1:0] irq_pend;
    logic            irq_take;
    logic [4:0]      irq_cause;
    logic            sel_intr;
    logic [4:0]      sel_cause;
    logic [XLEN-1:0] sel_pc, sel_tval;
    logic [XLEN-1:0] trap_base, trap_target;
    logic [XLEN-1:0] mstatus_trap, mstatus_ret;
    logic            unused_bits;

    always_comb begin
        irq_pend  = mip_i & mie_i;
        irq_take  = mstatus_i[MIE_B] & (irq_pend[MEI_B] | irq_pend[MSI_B] | irq_pend[MTI_B]);
        irq_cause = irq_pend[MEI_B] ? 5'd11 : (irq_pend[MSI_B] ? 5'd3 : 5'd7);

        // Only meaningful on a trap accept, where no exception means interrupt.
        sel_intr  = !exc_valid_i;
        sel_cause = exc_valid_i ? exc_cause_i : irq_cause;
        sel_pc    = exc_valid_i ? exc_pc_i : irq_pc_i;
        sel_tval  = exc_valid_i ? exc_tval_i : '0;

        trap_base = {mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        trap_target = (mtvec_i[1:0] == 2'b01 && sel_intr)
                    ? trap_base + (XLEN'(sel_cause) << 2) : trap_base;
`else
        trap_target = trap_base;
`endif

        mstatus_trap                      = mstatus_i;
        mstatus_trap[MPIE_B]              = mstatus_i[MIE_B];
        mstatus_trap[MIE_B]               = 1'b0;
        mstatus_trap[MPP_LO+1:MPP_LO]     = 2'b11;

        mstatus_ret                       = mstatus_i;
        mstatus_ret[MIE_B]                = mstatus_i[MPIE_B];
        mstatus_ret[MPIE_B]               = 1'b1;
        mstatus_ret[MPP_LO+1:MPP_LO]      = 2'b11;

        unused_bits = ^{irq_pend, mtvec_i[1:0], mepc_i[1:0], exc_pc_i[1:0], irq_pc_i[1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next       = state;
        accept_trap      = 1'b0;
        accept_ret       = 1'b0;
        busy_o           = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        mstatus_we_o     = 1'b0;
        mepc_we_o        = 1'b0;
        mcause_we_o      = 1'b0;
        mtval_we_o       = 1'b0;
        case (state)
            IDLE: begin
                if (exc_valid_i) begin
                    accept_trap = 1'b1;
                    state_next  = TRAP;
                end else if (mret_valid_i) begin
                    accept_ret  = 1'b1;
                    state_next  = RET;
                end else if (irq_take) begin
                    accept_trap = 1'b1;
                    state_next  = TRAP;
                end
            end
            TRAP: begin
                busy_o       = 1'b1;
                flush_o      = 1'b1;
                mstatus_we_o = 1'b1;
                mepc_we_o    = 1'b1;
                mcause_we_o  = 1'b1;
                mtval_we_o   = 1'b1;
                state_next   = REDIR;
            end
            RET: begin
                busy_o       = 1'b1;
                flush_o      = 1'b1;
                mstatus_we_o = 1'b1;
                state_next   = REDIR;
            end
            REDIR: begin
                busy_o           = 1'b1;
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write data and target are computed at the accept edge so they stay stable
    // through TRAP/RET and REDIR regardless of input changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_o     <= '0;
            mepc_o        <= '0;
            mcause_o      <= '0;
            mtval_o       <= '0;
            redirect_pc_o <= '0;
        end else if (accept_trap) begin
            mstatus_o     <= mstatus_trap;
            mepc_o        <= {sel_pc[XLEN-1:2], 2'b00};
            mcause_o      <= {sel_intr, {(XLEN-6){1'b0}}, sel_cause};
            mtval_o       <= sel_tval;
            redirect_pc_o <= trap_target;
        end else if (accept_ret) begin
            mstatus_o     <= mstatus_ret;
            redirect_pc_o <= {mepc_i[XLEN-1:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_m_trap_ctrl.sv
// Scoreboard bench for m_trap_ctrl: expected CSR writes and redirect targets are queued
// when an event is driven and consumed by a negedge monitor.
module tb_m_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        exc_valid_i;
    logic [4:0]  exc_cause_i;
    logic [31:0] exc_pc_i, exc_tval_i;
    logic        mret_valid_i;
    logic [31:0] irq_pc_i, mstatus_i, mtvec_i, mepc_i, mip_i, mie_i;
    logic        busy_o, flush_o, redirect_valid_o, redirect_ready_i;
    logic [31:0] redirect_pc_o;
    logic        mstatus_we_o, mepc_we_o, mcause_we_o, mtval_we_o;
    logic [31:0] mstatus_o, mepc_o, mcause_o, mtval_o;

    typedef struct {
        bit          ret;
        logic [31:0] mstatus;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] target;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   prev_flush = 0;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] TIMER_TGT = 32'h8000_001C;
`else
    localparam logic [31:0] TIMER_TGT = 32'h8000_0000;
`endif

    m_trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
        .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .mret_valid_i(mret_valid_i), .irq_pc_i(irq_pc_i),
        .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .mip_i(mip_i), .mie_i(mie_i),
        .busy_o(busy_o), .flush_o(flush_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i),
        .mstatus_we_o(mstatus_we_o), .mepc_we_o(mepc_we_o),
        .mcause_we_o(mcause_we_o), .mtval_we_o(mtval_we_o),
        .mstatus_o(mstatus_o), .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input bit ret, input logic [31:0] ms, input logic [31:0] pc,
                                input logic [31:0] cause, input logic [31:0] tval,
                                input logic [31:0] tgt);
        exp_t e;
        e.ret = ret; e.mstatus = ms; e.mepc = pc; e.mcause = cause; e.mtval = tval; e.target = tgt;
        return e;
    endfunction

    // Monitor: CSR writes on the flush cycle, target on the handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (flush_o) begin
                    check("flush_pulse", {31'b0, prev_flush}, 0);
                    if (q.size() == 0) begin
                        check("unexpected_flush", {31'b0, flush_o}, 0);
                    end else begin
                        e = q[0];
                        check("we_bits", {28'b0, mstatus_we_o, mepc_we_o, mcause_we_o, mtval_we_o},
                              e.ret ? 32'h8 : 32'hF);
                        check("mstatus_o", mstatus_o, e.mstatus);
                        if (!e.ret) begin
                            check("mepc_o", mepc_o, e.mepc);
                            check("mcause_o", mcause_o, e.mcause);
                            check("mtval_o", mtval_o, e.mtval);
                        end
                    end
                end else begin
                    check("we_quiet", {28'b0, mstatus_we_o, mepc_we_o, mcause_we_o, mtval_we_o}, 0);
                end
                if (redirect_valid_o && redirect_ready_i) begin
                    if (q.size() == 0) begin
                        check("unexpected_redirect", {31'b0, redirect_valid_o}, 0);
                    end else begin
                        e = q.pop_front();
                        check("redirect_pc", redirect_pc_o, e.target);
                    end
                end
            end
            prev_flush = flush_o;
        end
    end

    // Inputs already set; accept edge is the next posedge, ready assumed high.
    task automatic run_seq(input bit clr_irq);
        @(posedge clk); #1;
        check("busy_t1", {31'b0, busy_o}, 1);
        check("flush_t1", {31'b0, flush_o}, 1);
        exc_valid_i  = 0;
        mret_valid_i = 0;
        if (clr_irq) mip_i = '0;
        @(posedge clk); #1;
        check("redir_t2", {31'b0, redirect_valid_o}, 1);
        check("busy_t2", {31'b0, busy_o}, 1);
        @(posedge clk); #1;
        check("busy_fall", {31'b0, busy_o}, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {25'b0, busy_o, flush_o, redirect_valid_o,
                              mstatus_we_o, mepc_we_o, mcause_we_o, mtval_we_o}, 0);
        check({tag, "_pc"}, redirect_pc_o, 0);
        check({tag, "_mstatus"}, mstatus_o, 0);
        check({tag, "_mepc"}, mepc_o, 0);
        check({tag, "_mcause"}, mcause_o, 0);
        check({tag, "_mtval"}, mtval_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; exc_valid_i = 0; exc_cause_i = 0; exc_pc_i = 0; exc_tval_i = 0;
        mret_valid_i = 0; irq_pc_i = 0; mstatus_i = 0; mtvec_i = 0; mepc_i = 0;
        mip_i = 0; mie_i = 0; redirect_ready_i = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (10) @(posedge clk);
        #1 check_all_zero("reset_idle");

        // Illegal instruction exception
        mstatus_i = 32'h0000_0008; mtvec_i = 32'h8000_0000;
        exc_cause_i = 5'd2; exc_pc_i = 32'h8000_0104; exc_tval_i = 32'h0000_DEAD; exc_valid_i = 1;
        q.push_back(mk(0, 32'h0000_1880, 32'h8000_0104, 32'h2, 32'hDEAD, 32'h8000_0000));
        run_seq(0);

        // Timer interrupt, vectored mtvec
        mtvec_i = 32'h8000_0001; irq_pc_i = 32'h8000_0300; mie_i = 32'h80; mip_i = 32'h80;
        q.push_back(mk(0, 32'h0000_1880, 32'h8000_0300, 32'h8000_0007, 32'h0, TIMER_TGT));
        run_seq(1);

        // Masked MEI
        mtvec_i = 32'h8000_0000; mstatus_i = 32'h0; mie_i = 32'h800; mip_i = 32'h800;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("masked_busy", {31'b0, busy_o}, 0);
        end
        mip_i = 0;

        // Exception beats simultaneous MEI+MTI; MEI taken right after
        mstatus_i = 32'h0006_0008; mie_i = 32'h880; mip_i = 32'h880; irq_pc_i = 32'h8000_0503;
        exc_cause_i = 5'd5; exc_pc_i = 32'h8000_0400; exc_tval_i = 32'h1234; exc_valid_i = 1;
        q.push_back(mk(0, 32'h0006_1880, 32'h8000_0400, 32'h5, 32'h1234, 32'h8000_0000));
        q.push_back(mk(0, 32'h0006_1880, 32'h8000_0500, 32'h8000_000B, 32'h0, 32'h8000_0000));
        run_seq(0);
        run_seq(1);
        mie_i = 0;

        // mret
        mstatus_i = 32'h0000_0080; mepc_i = 32'h8000_0203; mret_valid_i = 1;
        q.push_back(mk(1, 32'h0000_1888, 32'h0, 32'h0, 32'h0, 32'h8000_0200));
        run_seq(0);

        // Backpressure; a new exception offered during REDIR must be ignored
        redirect_ready_i = 0;
        mstatus_i = 32'h0000_0008; mtvec_i = 32'h8000_1000;
        exc_cause_i = 5'd4; exc_pc_i = 32'h8000_0602; exc_tval_i = 32'h600; exc_valid_i = 1;
        q.push_back(mk(0, 32'h0000_1880, 32'h8000_0600, 32'h4, 32'h600, 32'h8000_1000));
        @(posedge clk); #1;
        check("bp_flush", {31'b0, flush_o}, 1);
        exc_valid_i = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, redirect_valid_o}, 1);
            check("bp_pc", redirect_pc_o, 32'h8000_1000);
            exc_valid_i = 1; exc_cause_i = 5'd7; exc_pc_i = 32'h9000_0000;
            @(posedge clk); #1;
        end
        exc_valid_i = 0; redirect_ready_i = 1;
        @(posedge clk); #1;
        check("bp_done_busy", {31'b0, busy_o}, 0);
        check("bp_queue", q.size(), 0);

        // Reset during REDIR
        redirect_ready_i = 0;
        exc_cause_i = 5'd1; exc_pc_i = 32'h8000_0700; exc_tval_i = 32'h77; exc_valid_i = 1;
        q.push_back(mk(0, 32'h0000_1880, 32'h8000_0700, 32'h1, 32'h77, 32'h8000_1000));
        @(posedge clk); #1;
        exc_valid_i = 0;
        @(posedge clk); #1;
        check("rst_pre_valid", {31'b0, redirect_valid_o}, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check_all_zero("rst_redir");
        q.delete();
        redirect_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_busy", {31'b0, busy_o}, 0);
        end

        check("final_queue", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
